// File: rtl/b02_scan_pkg.sv
// b02_scan_pkg: shared types and defaults for the b02 scan controller
package b02_scan_pkg;
  localparam int CHAIN_LEN_DEF = 4;
  typedef enum logic [2:0] {IDLE, SHIFT, CAPTURE, WAIT, FLUSH} state_t;
  typedef struct packed {
    logic [CHAIN_LEN_DEF-1:0] data;
    logic                     linea;
    logic [CHAIN_LEN_DEF-1:0] exp;
    logic                     last;
  } pat_t;
endpackage

// File: rtl/b02_pat_buffer.sv
// b02_pat_buffer: one-entry valid/ready holding register with full flag
module b02_pat_buffer #(
  parameter int W = 10
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic         drain,
  input  logic [W-1:0] d,
  output logic         full,
  output logic         ready,
  output logic [W-1:0] q
);
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      full <= 1'b0;
      q    <= '0;
    end else if (load) begin
      full <= 1'b1;
      q    <= d;
    end else if (drain) begin
      full <= 1'b0;
    end
  assign ready = ~full;
endmodule

// File: rtl/b02_scan_ctrl.sv
// b02_scan_ctrl: full-scan load/capture/unload sequencer for the b02 core
module b02_scan_ctrl
  import b02_scan_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int CNT_W     = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 pat_valid,
  output logic                 pat_ready,
  input  logic [CHAIN_LEN-1:0] pat_data,
  input  logic                 pat_linea,
  input  logic [CHAIN_LEN-1:0] pat_exp,
  input  logic                 pat_last,
  output logic                 sc_en,
  output logic                 sc_si,
  input  logic                 sc_so,
  output logic                 cap_en,
  output logic                 core_linea,
  output logic                 res_valid,
  output logic [CHAIN_LEN-1:0] res_data,
  output logic                 res_fail,
  output logic [CNT_W-1:0]     pat_cnt,
  output logic [CNT_W-1:0]     fail_cnt,
  output logic                 busy
);
  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int PW = 2 * CHAIN_LEN + 2;
  state_t state, next_state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] buf_q;
  logic [CHAIN_LEN-1:0] shifter, unload, cur_exp, cap_exp, resp;
  logic cur_linea, cur_last, unload_pending, buf_full, last, take, fin, fail_now;
  b02_pat_buffer #(.W(PW)) u_buf (
    .clock (clock),
    .reset (reset),
    .load  (pat_valid && pat_ready),
    .drain (take),
    .d     ({pat_data, pat_linea, pat_exp, pat_last}),
    .full  (buf_full),
    .ready (pat_ready),
    .q     (buf_q)
  );
  assign last     = cnt == CW'(CHAIN_LEN - 1);
  assign take     = buf_full && (state == IDLE || state == WAIT || (state == CAPTURE && !cur_last));
  assign resp     = {unload[CHAIN_LEN-2:0], sc_so};
  assign fin      = last && ((state == SHIFT && unload_pending) || state == FLUSH);
  assign fail_now = resp != cap_exp;
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else       state <= next_state;
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    next_state = buf_full ? SHIFT : IDLE;
      SHIFT:   next_state = last ? CAPTURE : SHIFT;
      CAPTURE: next_state = cur_last ? FLUSH : buf_full ? SHIFT : WAIT;
      WAIT:    next_state = buf_full ? SHIFT : WAIT;
      FLUSH:   next_state = last ? IDLE : FLUSH;
      default: next_state = IDLE;
    endcase
  end
  always_comb begin
    sc_en      = state == SHIFT || state == FLUSH;
    sc_si      = state == SHIFT && shifter[CHAIN_LEN-1];
    cap_en     = state == CAPTURE;
    core_linea = state == CAPTURE && cur_linea;
    busy       = state != IDLE;
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      cnt            <= '0;
      shifter        <= '0;
      unload         <= '0;
      cur_exp        <= '0;
      cur_linea      <= 1'b0;
      cur_last       <= 1'b0;
      cap_exp        <= '0;
      unload_pending <= 1'b0;
      res_valid      <= 1'b0;
      res_data       <= '0;
      res_fail       <= 1'b0;
      pat_cnt        <= '0;
      fail_cnt       <= '0;
    end else begin
      res_valid <= fin;
      cnt       <= (sc_en && !last) ? cnt + CW'(1) : '0;
      if (take) begin
        shifter   <= buf_q[PW-1 -: CHAIN_LEN];
        cur_linea <= buf_q[CHAIN_LEN+1];
        cur_exp   <= buf_q[CHAIN_LEN:1];
        cur_last  <= buf_q[0];
      end else if (state == SHIFT) begin
        shifter <= shifter << 1;
      end
      if (sc_en) unload <= resp;
      if (cap_en) begin
        cap_exp        <= cur_exp;
        unload_pending <= 1'b1;
      end else if (state == FLUSH && last) begin
        unload_pending <= 1'b0;
      end
      if (fin) begin
        res_data <= resp;
        res_fail <= fail_now;
        pat_cnt  <= pat_cnt + CNT_W'(1);
        if (fail_now && !(&fail_cnt)) fail_cnt <= fail_cnt + CNT_W'(1);
      end
    end
endmodule

// File: tb/tb_b02_scan_ctrl.sv
// tb_b02_scan_ctrl: directed self-checking bench with a behavioural 4-bit chain
module tb_b02_scan_ctrl;
  typedef struct {
    logic [3:0] data;
    logic       linea;
    logic [3:0] exp;
    logic [3:0] res;
    logic       fail;
  } vec_t;
  logic clock = 1'b0, reset = 1'b0;
  logic pat_valid = 1'b0, pat_linea = 1'b0, pat_last = 1'b0;
  logic [3:0] pat_data = '0, pat_exp = '0;
  logic pat_ready, sc_en, sc_si, sc_so, cap_en, core_linea, res_valid, res_fail, busy;
  logic [3:0] res_data;
  logic [7:0] pat_cnt, fail_cnt;
  logic pat_ready2, sc_en2, sc_si2, sc_so2, cap_en2, core_linea2, res_valid2, res_fail2, busy2;
  logic [3:0] res_data2;
  logic [1:0] pat_cnt2, fail_cnt2;
  logic [3:0] chain1 = '0, chain2 = '0;
  int cyc = 0, t0 = 0, tests = 0, fails = 0;
  vec_t tbl [6];
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  b02_scan_ctrl #(.CHAIN_LEN(4), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .pat_valid(pat_valid), .pat_ready(pat_ready),
    .pat_data(pat_data), .pat_linea(pat_linea), .pat_exp(pat_exp), .pat_last(pat_last),
    .sc_en(sc_en), .sc_si(sc_si), .sc_so(sc_so), .cap_en(cap_en), .core_linea(core_linea),
    .res_valid(res_valid), .res_data(res_data), .res_fail(res_fail),
    .pat_cnt(pat_cnt), .fail_cnt(fail_cnt), .busy(busy)
  );
  b02_scan_ctrl #(.CHAIN_LEN(4), .CNT_W(2)) dut2 (
    .clock(clock), .reset(reset), .pat_valid(pat_valid), .pat_ready(pat_ready2),
    .pat_data(pat_data), .pat_linea(pat_linea), .pat_exp(pat_exp), .pat_last(pat_last),
    .sc_en(sc_en2), .sc_si(sc_si2), .sc_so(sc_so2), .cap_en(cap_en2), .core_linea(core_linea2),
    .res_valid(res_valid2), .res_data(res_data2), .res_fail(res_fail2),
    .pat_cnt(pat_cnt2), .fail_cnt(fail_cnt2), .busy(busy2)
  );
  assign sc_so  = chain1[3];
  assign sc_so2 = chain2[3];
  always @(posedge clock) begin
    if (sc_en) chain1 <= {chain1[2:0], sc_si};
    else if (cap_en) chain1 <= ~chain1 ^ {3'b000, core_linea};
    if (sc_en2) chain2 <= {chain2[2:0], sc_si2};
    else if (cap_en2) chain2 <= ~chain2 ^ {3'b000, core_linea2};
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    pat_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask
  task automatic feed(input vec_t v, input logic last);
    int n = 0;
    pat_valid = 1'b1;
    pat_data  = v.data;
    pat_linea = v.linea;
    pat_exp   = v.exp;
    pat_last  = last;
    while (!pat_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!pat_ready) check("feed_timeout", 0, 1);
    @(negedge clock);
    pat_valid = 1'b0;
  endtask
  task automatic wait_res(output int rel);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!res_valid && n < 100);
    rel = cyc - t0;
    if (!res_valid) check("res_timeout", 0, 1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int rel;
    int caps[$], rvs[$];
    logic [3:0] rds[$];
    logic [3:0] snap;
    logic wait_bad, saw_wait;
    vec_t p;
    tbl[0] = '{4'b1010, 1'b0, 4'b0101, 4'b0101, 1'b0};
    tbl[1] = '{4'b1010, 1'b1, 4'b1111, 4'b0100, 1'b1};
    tbl[2] = '{4'b0000, 1'b1, 4'b1110, 4'b1110, 1'b0};
    tbl[3] = '{4'b1111, 1'b0, 4'b0000, 4'b0000, 1'b0};
    tbl[4] = '{4'b0110, 1'b1, 4'b1000, 4'b1000, 1'b0};
    tbl[5] = '{4'b1100, 1'b0, 4'b0000, 4'b0011, 1'b1};
    do_reset();
    check("rst_pat_ready", pat_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_sc_en_cap_en", {sc_en, cap_en, sc_si, core_linea}, 0);
    check("rst_counters", {pat_cnt, fail_cnt}, 0);
    for (int i = 0; i < 6; i++) begin
      do_reset();
      t0 = cyc;
      feed(tbl[i], 1'b1);
      check($sformatf("v%0d_idle_c1", i), {busy, pat_ready}, 0);
      wait_res(rel);
      check($sformatf("v%0d_latency", i), rel, 11);
      check($sformatf("v%0d_res_data", i), res_data, tbl[i].res);
      check($sformatf("v%0d_res_fail", i), res_fail, tbl[i].fail);
      check($sformatf("v%0d_pat_cnt", i), pat_cnt, 1);
      check($sformatf("v%0d_fail_cnt", i), fail_cnt, tbl[i].fail);
      check($sformatf("v%0d_busy_c11", i), busy, 0);
    end
    do_reset();
    t0 = cyc;
    saw_wait = 1'b0;
    fork
      begin
        p = '{4'b1010, 1'b0, 4'b0101, 4'b0, 1'b0};
        feed(p, 1'b0);
        p = '{4'b0011, 1'b1, 4'b1101, 4'b0, 1'b0};
        feed(p, 1'b0);
        p = '{4'b1001, 1'b0, 4'b0110, 4'b0, 1'b0};
        feed(p, 1'b1);
      end
      begin
        repeat (22) begin
          @(negedge clock);
          if (cap_en) caps.push_back(cyc - t0);
          if (res_valid) begin
            rvs.push_back(cyc - t0);
            rds.push_back(res_data);
          end
          if (busy && !sc_en && !cap_en) saw_wait = 1'b1;
        end
      end
    join
    check("stream_ncap", caps.size(), 3);
    check("stream_nres", rvs.size(), 3);
    if (caps.size() == 3 && rvs.size() == 3) begin
      check("stream_cap0", caps[0], 6);
      check("stream_cap1", caps[1], 11);
      check("stream_cap2", caps[2], 16);
      check("stream_res0", rvs[0], 11);
      check("stream_res1", rvs[1], 16);
      check("stream_res2", rvs[2], 21);
      check("stream_data0", rds[0], 4'b0101);
      check("stream_data1", rds[1], 4'b1101);
      check("stream_data2", rds[2], 4'b0110);
    end
    check("stream_no_wait", saw_wait, 0);
    check("stream_counts", {pat_cnt, fail_cnt}, {8'd3, 8'd0});
    do_reset();
    t0 = cyc;
    wait_bad = 1'b0;
    snap = '0;
    p = '{4'b0101, 1'b1, 4'b1011, 4'b0, 1'b0};
    feed(p, 1'b0);
    while (cyc - t0 < 13) begin
      @(negedge clock);
      if (cyc - t0 == 7) snap = chain1;
      if (cyc - t0 >= 7 && (sc_en || cap_en || !busy)) wait_bad = 1'b1;
    end
    check("wait_outputs", wait_bad, 0);
    check("wait_chain_val", snap, 4'b1011);
    check("wait_chain_held", chain1, snap);
    p = '{4'b1110, 1'b0, 4'b0001, 4'b0, 1'b0};
    feed(p, 1'b1);
    wait_res(rel);
    check("wait_res0_cyc", rel, 19);
    check("wait_res0_data", {res_data, res_fail}, {4'b1011, 1'b0});
    wait_res(rel);
    check("wait_res1_cyc", rel, 24);
    check("wait_res1_data", {res_data, res_fail}, {4'b0001, 1'b0});
    do_reset();
    for (int i = 0; i < 5; i++) begin
      t0 = cyc;
      p = '{4'(i), 1'b0, 4'(i), 4'b0, 1'b0};
      feed(p, 1'b1);
      wait_res(rel);
      check($sformatf("sat%0d_fail2", i), fail_cnt2, (i + 1 > 3) ? 3 : i + 1);
      check($sformatf("sat%0d_pat2", i), pat_cnt2, (i + 1) % 4);
    end
    check("sat_fail8", fail_cnt, 5);
    check("sat_pat8", pat_cnt, 5);
    do_reset();
    t0 = cyc;
    p = '{4'b1010, 1'b0, 4'b0101, 4'b0, 1'b0};
    feed(p, 1'b1);
    feed(p, 1'b1);
    @(negedge clock);
    check("rst_mid_in_shift", {busy, sc_en}, 2'b11);
    reset = 1'b1;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_outs", {sc_en, cap_en, sc_si, core_linea, res_valid}, 0);
    check("rst_mid_ready", pat_ready, 1);
    check("rst_mid_cnt", pat_cnt, 0);
    @(negedge clock);
    reset = 1'b0;
    wait_bad = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (res_valid || busy) wait_bad = 1'b1;
    end
    check("rst_mid_quiet", wait_bad, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/b02_scan_ctrl.md
# b02_scan_ctrl

Full-scan test sequencer for the b02 serial-recognizer core, whose combinational next-state logic exposes its state flops (U_REG, STATO_REG_2..0) as a scan chain. The controller accepts parallel test patterns, serially shifts each into the chain, and issues one capture cycle with the pattern's LINEA value. While the next pattern shifts in, it unloads the previous response, compares it to the expected value, and keeps pass/fail statistics.

## Interface
Parameters:
- CHAIN_LEN, 4, scan chain length (U_REG + 3 state bits); must be ≥ 2
- CNT_W, 8, width of pat_cnt / fail_cnt

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- pat_valid  in  1  pattern offered
- pat_ready  out  1  one-entry input buffer empty
- pat_data  in  CHAIN_LEN  chain load value
- pat_linea  in  1  LINEA value applied during capture
- pat_exp  in  CHAIN_LEN  expected captured chain contents
- pat_last  in  1  final pattern; controller flushes its response afterwards
- sc_en  out  1  chain shift enable
- sc_si  out  1  chain serial in
- sc_so  in  1  chain serial out (cell CHAIN_LEN-1)
- cap_en  out  1  core functional-clock enable (capture)
- core_linea  out  1  LINEA driven to core
- res_valid  out  1  one-cycle response strobe
- res_data  out  CHAIN_LEN  unloaded response
- res_fail  out  1  res_data != expected; valid with res_valid
- pat_cnt  out  CNT_W  responses produced, wraps
- fail_cnt  out  CNT_W  failing responses, saturates at 2^CNT_W-1
- busy  out  1  state != IDLE

## Operation
- Input buffer: transfer on pat_valid && pat_ready. pat_ready = registered buffer-empty flag. It cannot accept in the same cycle the buffer drains; pat_ready rises the cycle after the drain.
- Shift order is MSB first in both directions: sc_si = pat_data[CHAIN_LEN-1] in the first shift cycle. The first sc_so sample lands in res_data[CHAIN_LEN-1].
- FSM states:
  - IDLE: if buffer full, move the buffer into the shifter plus cur_linea/cur_exp/cur_last, then go to SHIFT.
  - SHIFT: CHAIN_LEN cycles with sc_en=1 and sc_si=shifter MSB. If unload_pending, sample sc_so each cycle. At the end, if unload_pending, pulse res_valid. Then go to CAPTURE.
  - CAPTURE: 1 cycle with sc_en=0, cap_en=1, core_linea=cur_linea. Copy cur_exp to cap_exp and set unload_pending=1. Next state: FLUSH if cur_last; else SHIFT if buffer full (load it); else WAIT.
  - WAIT: sc_en=0, cap_en=0; chain holds. Go to SHIFT when the buffer fills.
  - FLUSH: CHAIN_LEN cycles with sc_en=1 and sc_si=0, sampling sc_so. Then pulse res_valid, clear unload_pending, go to IDLE.
- res_fail = (res_data != cap_exp). pat_cnt increments on every res_valid. fail_cnt increments on res_valid && res_fail, saturating.
- core_linea is 0 outside CAPTURE.
- sc_en and cap_en are never both 1.

## Timing
- Reset values:
  - 1: pat_ready.
  - 0: all other outputs, unload_pending, the buffer, and the counters.
  - FSM: IDLE.
- Reset mid-operation aborts immediately: no res_valid, the buffered pattern is dropped, and the chain contents are don't-care.
- A single pattern with pat_last, CHAIN_LEN=4, handshake at the end of cycle 0:
  - Cycle 1: IDLE.
  - Cycles 2–5: SHIFT.
  - Cycle 6: CAPTURE.
  - Cycles 7–10: FLUSH.
  - Cycle 11: res_valid=1, state IDLE.
- Streaming (buffer always refilled before CAPTURE) takes CHAIN_LEN+1 cycles per pattern.
- res_valid, res_data and res_fail are registered. res_valid is asserted in the cycle after the last sampling cycle. res_data holds until the next res_valid.
- The counters update in the same cycle res_valid asserts.
- pat_cnt wraps from 2^CNT_W-1 to 0.

## Structure
- Package b02_scan_pkg: state enum (IDLE, SHIFT, CAPTURE, WAIT, FLUSH), default CHAIN_LEN, and a pattern struct {data, linea, exp, last}.
- Sub-module b02_pat_buffer: one-entry valid/ready holding register with full flag, load and drain.
- Top level contains the FSM, a shift counter of $clog2(CHAIN_LEN+1) bits, the shifter, the unload register and the counters.

## Test plan
The bench uses a behavioural 4-bit chain model: shift when sc_en is high; when cap_en is high, the chain inverts and XORs core_linea into bit 0.
- Single pattern, data=4'b1010, linea=0, exp=4'b0101, last=1 -> res_valid in cycle 11, res_data=4'b0101, res_fail=0, pat_cnt=1, busy low in cycle 11.
- Three back-to-back patterns with the buffer always full -> CAPTURE every 5 cycles, three res_valid, the last from FLUSH, no WAIT visited.
- Wrong exp (4'b1111 for data 4'b1010, linea=1) -> res_data=4'b0100, res_fail=1, fail_cnt=1.
- Delay the second pattern by 7 cycles after the first CAPTURE -> FSM in WAIT with sc_en=0, cap_en=0 and the chain unchanged; the response is still correct.
- CNT_W=2 with 5 failing patterns -> fail_cnt stays at 3, pat_cnt=1.
- Assert reset in the 3rd SHIFT cycle -> outputs return to reset values at once, no res_valid, pat_ready=1.
